insn_queue: RTL and testbench

- Per-thread instruction queue at the consumer end of the fetch aligner interface.
- Accepts 0-4 aligned instructions per cycle, qualified by a left-packed 4-bit valid mask.
- Buffers them in a circular FIFO and presents up to 2 oldest instructions per cycle to issue/rename.
- Back-pressures fetch with a stall signal; a branch-redirect flush empties it.

---
 rtl/insn_queue_pkg.sv | 25 ++
 rtl/insn_queue_storage.sv | 38 +++
 rtl/insn_queue.sv | 119 +++++++++++
 tb/tb_insn_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/insn_queue_pkg.sv
// Shared definitions for the per-thread instruction queues and the fetch aligner:
// left-packed valid-mask encodings and the mask-to-count decoder.
package insn_queue_pkg;

  localparam int unsigned INSN_WIDTH_DEFAULT = 99;

  // Left-packed enqueue masks; bit3 qualifies the oldest instruction.
  localparam logic [3:0] VM_NONE = 4'b0000;
  localparam logic [3:0] VM_1    = 4'b1000;
  localparam logic [3:0] VM_2    = 4'b1100;
  localparam logic [3:0] VM_3    = 4'b1110;
  localparam logic [3:0] VM_4    = 4'b1111;

  // Number of leading ones from bit3 downwards; anything after the first zero is ignored.
  function automatic logic [2:0] mask_to_count(input logic [3:0] mask);
    logic [2:0] n;
    n = 3'd0;
    if (mask == VM_4)                  n = 3'd4;
    else if (mask[3:1] == VM_3[3:1])   n = 3'd3;
    else if (mask[3:2] == VM_2[3:2])   n = 3'd2;
    else if (mask[3] == VM_1[3])       n = 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/insn_queue_storage.sv
// Instruction storage: DEPTH x INSN_WIDTH register array with four write ports
// at consecutive (wrapping) addresses and two asynchronous read ports.
module insn_queue_storage
  import insn_queue_pkg::*;
#(
  parameter int unsigned INSN_WIDTH = INSN_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_WIDTH  = 4
) (
  input  logic                        clk_i,
  input  logic [PTR_WIDTH-1:0]        wr_base_i,
  input  logic [3:0]                  wr_en_i,
  input  logic [3:0][INSN_WIDTH-1:0]  wr_data_i,
  input  logic [PTR_WIDTH-1:0]        rd_addr0_i,
  input  logic [PTR_WIDTH-1:0]        rd_addr1_i,
  output logic [INSN_WIDTH-1:0]       rd_data0_o,
  output logic [INSN_WIDTH-1:0]       rd_data1_o
);

  logic [INSN_WIDTH-1:0] mem_q [DEPTH];

  // Write port k lands at wr_base_i + k; pointer-width arithmetic wraps to entry 0.
  // NOTE: the array has no reset; validity is tracked by the pointers and count,
  // so clearing it would only add a large reset fan-out for no functional gain.
  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en_i[k]) begin
        mem_q[wr_base_i + PTR_WIDTH'(k)] <= wr_data_i[k];
      end
    end
  end

  assign rd_data0_o = mem_q[rd_addr0_i];
  assign rd_data1_o = mem_q[rd_addr1_i];

endmodule

// File: rtl/insn_queue.sv
// Per-thread instruction queue: accepts up to four aligned instructions per cycle,
// presents the two oldest to issue, back-pressures fetch and empties on flush.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int unsigned INSN_WIDTH = INSN_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_WIDTH  = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Flush,
  input  logic [3:0]             i_valid,
  input  logic [INSN_WIDTH-1:0]  i_isn1,
  input  logic [INSN_WIDTH-1:0]  i_isn2,
  input  logic [INSN_WIDTH-1:0]  i_isn3,
  input  logic [INSN_WIDTH-1:0]  i_isn4,
  output logic                   o_Stall,
  input  logic [1:0]             i_deq_count,
  output logic [1:0]             o_deq_valid,
  output logic [INSN_WIDTH-1:0]  o_isn_out1,
  output logic [INSN_WIDTH-1:0]  o_isn_out2,
  output logic [PTR_WIDTH:0]     o_count
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] FOUR_C  = (PTR_WIDTH+1)'(4);
  localparam logic [PTR_WIDTH:0] TWO_C   = (PTR_WIDTH+1)'(2);

  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;

  logic [PTR_WIDTH:0]   free_slots;
  logic [2:0]           enq_n;
  logic                 enq_accept;
  logic [2:0]           enq_acc_n;
  logic [1:0]           deq_req;
  logic [1:0]           deq_avail;
  logic [1:0]           deq_n;
  logic [3:0]           wr_en;
  logic [3:0][INSN_WIDTH-1:0] wr_data;
  logic [INSN_WIDTH-1:0] rd_data0, rd_data1;

  // Stall is conservative: it looks only at registered occupancy, never at a same-cycle dequeue.
  assign free_slots = DEPTH_C - count_q;
  assign o_Stall    = (free_slots < FOUR_C);

  // Enqueue/dequeue amounts, write enables and next pointer state; flush wins over both.
  // NOTE: every signal gets a default at the top of the block so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en     = 4'b0000;

    enq_n      = mask_to_count(i_valid);
    enq_accept = (enq_n != 3'd0) && !o_Stall && !i_Flush;
    enq_acc_n  = enq_accept ? enq_n : 3'd0;

    deq_req   = (i_deq_count == 2'd3) ? 2'd2 : i_deq_count;
    deq_avail = (count_q >= TWO_C) ? 2'd2 : count_q[1:0];
    deq_n     = (deq_req < deq_avail) ? deq_req : deq_avail;

    for (int k = 0; k < 4; k++) begin
      wr_en[k] = enq_accept && (3'(k) < enq_n);
    end

    if (i_Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_WIDTH'(deq_n);
      tail_d  = tail_q + PTR_WIDTH'(enq_acc_n);
      count_d = count_q + (PTR_WIDTH+1)'(enq_acc_n) - (PTR_WIDTH+1)'(deq_n);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Port 0 carries the oldest instruction (i_isn1).
  assign wr_data = {i_isn4, i_isn3, i_isn2, i_isn1};

  insn_queue_storage #(
    .INSN_WIDTH (INSN_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_storage (
    .clk_i      (i_Clk),
    .wr_base_i  (tail_q),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_addr0_i (head_q),
    .rd_addr1_i (head_q + PTR_WIDTH'(1)),
    .rd_data0_o (rd_data0),
    .rd_data1_o (rd_data1)
  );

  // Head-entry presentation, zeroed where the entry is not valid; all derived
  // from registered count, so reset clears them immediately.
  assign o_deq_valid = {(count_q != '0), (count_q >= TWO_C)};
  assign o_isn_out1  = o_deq_valid[1] ? rd_data0 : '0;
  assign o_isn_out2  = o_deq_valid[0] ? rd_data1 : '0;
  assign o_count     = count_q;

endmodule

// File: tb/tb_insn_queue.sv
// Self-checking bench for insn_queue: a table of per-cycle vectors with explicit
// expected occupancy/flags, plus a FIFO scoreboard for instruction ordering.
module tb_insn_queue;
  import insn_queue_pkg::*;

  localparam int W     = 99;
  localparam int DEPTH = 16;
  localparam int NVEC  = 30;

  typedef struct {
    logic [3:0] valid;
    logic [1:0] deq;
    logic       flush;
    int         exp_count;
    logic [1:0] exp_dv;
    logic       exp_stall;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [3:0]    valid;
  logic [W-1:0]  isn1, isn2, isn3, isn4;
  logic          stall;
  logic [1:0]    deq_count;
  logic [1:0]    deq_valid;
  logic [W-1:0]  out1, out2;
  logic [4:0]    count;

  int checks   = 0;
  int failures = 0;
  int seq      = 0;
  logic [W-1:0] sb[$];
  vec_t vecs[NVEC];

  insn_queue #(.INSN_WIDTH(W), .DEPTH(DEPTH), .PTR_WIDTH(4)) u_dut (
    .i_Clk       (clk),
    .i_Reset_n   (rst_n),
    .i_Flush     (flush),
    .i_valid     (valid),
    .i_isn1      (isn1),
    .i_isn2      (isn2),
    .i_isn3      (isn3),
    .i_isn4      (isn4),
    .o_Stall     (stall),
    .i_deq_count (deq_count),
    .o_deq_valid (deq_valid),
    .o_isn_out1  (out1),
    .o_isn_out2  (out2),
    .o_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int lead_ones(input logic [3:0] m);
    int n;
    n = 0;
    for (int b = 3; b >= 0; b--) begin
      if (!m[b]) break;
      n++;
    end
    return n;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [1:0] d, input logic f,
                              input int c, input logic [1:0] dv, input logic s);
    vec_t r;
    r.valid = v; r.deq = d; r.flush = f;
    r.exp_count = c; r.exp_dv = dv; r.exp_stall = s;
    return r;
  endfunction

  // Apply one cycle of stimulus, update the scoreboard, and compare after the edge.
  task automatic step(input vec_t v, input string tag);
    logic [W-1:0] isn[4];
    int n, req, d;
    bit stall_m, acc;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      isn[k] = {3'b101, 32'($urandom), 32'(seq), 32'($urandom)};
      seq++;
    end
    valid = v.valid; deq_count = v.deq; flush = v.flush;
    isn1 = isn[0]; isn2 = isn[1]; isn3 = isn[2]; isn4 = isn[3];
    #1;
    stall_m = (DEPTH - sb.size()) < 4;
    check({tag, ".stall_pre"}, stall, stall_m);
    n   = lead_ones(v.valid);
    acc = (n > 0) && !stall_m && !v.flush;
    req = (v.deq == 2'd3) ? 2 : int'(v.deq);
    d   = (req < sb.size()) ? req : sb.size();
    if (v.flush) begin
      sb.delete();
    end else begin
      repeat (d) void'(sb.pop_front());
      if (acc) for (int k = 0; k < n; k++) sb.push_back(isn[k]);
    end
    @(posedge clk);
    #1;
    check({tag, ".count_model"}, count, sb.size());
    check({tag, ".count"},       count, v.exp_count);
    check({tag, ".deq_valid"},   deq_valid, v.exp_dv);
    check({tag, ".stall"},       stall, v.exp_stall);
    check({tag, ".out1"}, out1, (sb.size() > 0) ? sb[0] : '0);
    check({tag, ".out2"}, out2, (sb.size() > 1) ? sb[1] : '0);
  endtask

  initial begin
    // valid,   deq, flush, count, dv, stall
    vecs[0]  = mk(VM_4,    2'd0, 1'b0,  4, 2'b11, 1'b0); // first group visible next cycle
    vecs[1]  = mk(VM_4,    2'd0, 1'b0,  8, 2'b11, 1'b0);
    vecs[2]  = mk(VM_4,    2'd0, 1'b0, 12, 2'b11, 1'b0);
    vecs[3]  = mk(VM_1,    2'd0, 1'b0, 13, 2'b11, 1'b1);
    vecs[4]  = mk(VM_2,    2'd0, 1'b0, 13, 2'b11, 1'b1); // stalled, group dropped
    vecs[5]  = mk(VM_NONE, 2'd2, 1'b0, 11, 2'b11, 1'b0);
    vecs[6]  = mk(VM_NONE, 2'd2, 1'b0,  9, 2'b11, 1'b0);
    vecs[7]  = mk(VM_NONE, 2'd3, 1'b0,  7, 2'b11, 1'b0); // 3 acts as 2
    vecs[8]  = mk(VM_NONE, 2'd2, 1'b0,  5, 2'b11, 1'b0);
    vecs[9]  = mk(VM_NONE, 2'd2, 1'b0,  3, 2'b11, 1'b0);
    vecs[10] = mk(VM_NONE, 2'd2, 1'b0,  1, 2'b10, 1'b0);
    vecs[11] = mk(VM_NONE, 2'd2, 1'b0,  0, 2'b00, 1'b0); // only one available
    vecs[12] = mk(4'b1011, 2'd0, 1'b0,  1, 2'b10, 1'b0); // gap after bit3 -> one entry
    vecs[13] = mk(VM_NONE, 2'd1, 1'b0,  0, 2'b00, 1'b0); // head = tail = 14
    vecs[14] = mk(VM_NONE, 2'd3, 1'b0,  0, 2'b00, 1'b0); // dequeue on empty ignored
    vecs[15] = mk(VM_4,    2'd0, 1'b0,  4, 2'b11, 1'b0); // writes 14,15,0,1
    vecs[16] = mk(VM_NONE, 2'd2, 1'b0,  2, 2'b11, 1'b0);
    vecs[17] = mk(VM_NONE, 2'd2, 1'b0,  0, 2'b00, 1'b0);
    vecs[18] = mk(VM_4,    2'd0, 1'b0,  4, 2'b11, 1'b0);
    vecs[19] = mk(VM_1,    2'd0, 1'b0,  5, 2'b11, 1'b0);
    vecs[20] = mk(VM_3,    2'd2, 1'b0,  6, 2'b11, 1'b0); // simultaneous enq/deq
    vecs[21] = mk(VM_3,    2'd0, 1'b0,  9, 2'b11, 1'b0);
    vecs[22] = mk(VM_4,    2'd2, 1'b1,  0, 2'b00, 1'b0); // flush beats enq and deq
    vecs[23] = mk(VM_4,    2'd0, 1'b0,  4, 2'b11, 1'b0);
    vecs[24] = mk(VM_4,    2'd0, 1'b0,  8, 2'b11, 1'b0);
    vecs[25] = mk(VM_4,    2'd0, 1'b0, 12, 2'b11, 1'b0);
    vecs[26] = mk(VM_4,    2'd0, 1'b0, 16, 2'b11, 1'b1); // full
    vecs[27] = mk(VM_4,    2'd2, 1'b0, 14, 2'b11, 1'b1); // dequeue from full, enqueue dropped
    vecs[28] = mk(VM_NONE, 2'd1, 1'b0, 13, 2'b11, 1'b1);
    vecs[29] = mk(VM_NONE, 2'd2, 1'b0, 11, 2'b11, 1'b0);

    rst_n = 1'b0; flush = 1'b0; valid = VM_NONE; deq_count = 2'd0;
    isn1 = '0; isn2 = '0; isn3 = '0; isn4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.count",     count, 5'd0);
    check("reset.deq_valid", deq_valid, 2'b00);
    check("reset.stall",     stall, 1'b0);
    check("reset.out1",      out1, '0);
    check("reset.out2",      out2, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset mid-cycle: outputs clear with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.count",     count, 5'd0);
    check("async_rst.deq_valid", deq_valid, 2'b00);
    check("async_rst.stall",     stall, 1'b0);
    check("async_rst.out1",      out1, '0);
    check("async_rst.out2",      out2, '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(VM_2,    2'd0, 1'b0, 2, 2'b11, 1'b0), "post_rst.enq");
    step(mk(VM_NONE, 2'd3, 1'b0, 0, 2'b00, 1'b0), "post_rst.deq");

    @(negedge clk);
    valid = VM_NONE; deq_count = 2'd0; flush = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
